// File: rtl/queue_pkg.sv
// Shared constants and helpers for the lockstep redundant queue.
package queue_pkg;

  localparam int MAX_COPIES = 4;

  function automatic int clog2_count(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/queue_core.sv
// Single-copy first-word-fall-through FIFO with rejection event strobes.
module queue_core
  import queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enq,
  input  logic                          deq,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic                          full,
  output logic                          empty,
  output logic [clog2_count(DEPTH)-1:0] count,
  output logic                          ovf_evt,
  output logic                          unf_evt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = clog2_count(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_enq_ok;
  logic             w_deq_ok;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign w_enq_ok = enq && (!full || deq);
  assign w_deq_ok = deq && !empty;
  assign ovf_evt  = enq && !w_enq_ok;
  assign unf_evt  = deq && !w_deq_ok;
  assign dout     = empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq_ok) r_wptr <= r_wptr + 1'b1;
      if (w_deq_ok) r_rptr <= r_rptr + 1'b1;
      if (w_enq_ok && !w_deq_ok)      r_count <= r_count + 1'b1;
      else if (!w_enq_ok && w_deq_ok) r_count <= r_count - 1'b1;
    end
  end

  // Storage needs no reset: dout is masked while empty.
  always_ff @(posedge clk) begin
    if (w_enq_ok) r_mem[r_wptr] <= din;
  end

endmodule

// File: rtl/queue_lockstep.sv
// Redundant lockstep FIFO: COPIES cores, copy 0 is functional, others checked.
module queue_lockstep
  import queue_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int COPIES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enq,
  input  logic                          deq,
  input  logic [WIDTH-1:0]              din,
  input  logic                          inj_en,
  input  logic [$clog2(COPIES)-1:0]     inj_sel,
  input  logic                          err_clr,
  output logic [WIDTH-1:0]              dout,
  output logic                          full,
  output logic                          empty,
  output logic [clog2_count(DEPTH)-1:0] count,
  output logic                          overflow,
  output logic                          underflow,
  output logic [COPIES-1:0]             mismatch_mask,
  output logic                          mismatch
);

  localparam int CW = clog2_count(DEPTH);
  localparam int IW = $clog2(COPIES);

  typedef struct packed {
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
  } tuple_t;

  if (COPIES < 2 || COPIES > MAX_COPIES) begin : g_bad_copies
    $error("COPIES must be 2..4");
  end
  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..256");
  end

  tuple_t            w_tup [COPIES];
  logic [COPIES-1:0] w_ovf;
  logic [COPIES-1:0] w_unf;
  logic [COPIES-1:0] w_diff;
  logic [COPIES-1:0] r_mask;
  logic              r_ovf;
  logic              r_unf;

  for (genvar c = 0; c < COPIES; c++) begin : g_copy
    logic [WIDTH-1:0] w_din;
    logic [WIDTH-1:0] w_dout;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;

    assign w_din = din ^ WIDTH'(inj_en && (inj_sel == IW'(c)));

    queue_core #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_core (
      .clk    (clk),
      .rst    (rst),
      .enq    (enq),
      .deq    (deq),
      .din    (w_din),
      .dout   (w_dout),
      .full   (w_full),
      .empty  (w_empty),
      .count  (w_count),
      .ovf_evt(w_ovf[c]),
      .unf_evt(w_unf[c])
    );

    assign w_tup[c] = '{dout: w_dout, full: w_full,
                        empty: w_empty, count: w_count};
  end

  always_comb begin
    w_diff = '0;
    for (int i = 1; i < COPIES; i++) begin
      w_diff[i] = (w_tup[i] !== w_tup[0]);
    end
  end

  // Fresh events OR in after the clear so they survive err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else begin
      r_mask <= (err_clr ? '0 : r_mask) | w_diff;
      r_ovf  <= (err_clr ? 1'b0 : r_ovf) | (|w_ovf);
      r_unf  <= (err_clr ? 1'b0 : r_unf) | (|w_unf);
    end
  end

  assign dout          = w_tup[0].dout;
  assign full          = w_tup[0].full;
  assign empty         = w_tup[0].empty;
  assign count         = w_tup[0].count;
  assign overflow      = r_ovf;
  assign underflow     = r_unf;
  assign mismatch_mask = r_mask;
  assign mismatch      = |r_mask;

endmodule

// File: tb/tb_queue_lockstep.sv
// Directed bench for queue_lockstep with a queue-based reference model.
module tb_queue_lockstep;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enq = 1'b0;
  logic        deq = 1'b0;
  logic [31:0] din = '0;
  logic        inj_en = 1'b0;
  logic [1:0]  inj_sel = '0;
  logic        err_clr = 1'b0;
  logic [31:0] dout;
  logic        full;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;
  logic [2:0]  mismatch_mask;
  logic        mismatch;

  int total = 0;
  int bad = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  logic [2:0]  m_mask = '0;

  queue_lockstep #(
    .WIDTH(32),
    .DEPTH(8),
    .COPIES(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enq          (enq),
    .deq          (deq),
    .din          (din),
    .inj_en       (inj_en),
    .inj_sel      (inj_sel),
    .err_clr      (err_clr),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .mismatch_mask(mismatch_mask),
    .mismatch     (mismatch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] hd(input int k);
    case (k)
      0: return q0.size() ? q0[0] : 32'h0;
      1: return q1.size() ? q1[0] : 32'h0;
      default: return q2.size() ? q2[0] : 32'h0;
    endcase
  endfunction

  // Reference model: three plain queues, heads compared before each edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q0.delete();
      q1.delete();
      q2.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_mask = '0;
    end else begin
      logic [2:0] d;
      logic ae, ad;
      d[0] = 1'b0;
      d[1] = (hd(1) != hd(0)) || (q1.size() != q0.size());
      d[2] = (hd(2) != hd(0)) || (q2.size() != q0.size());
      ae = enq && ((q0.size() < 8) || deq);
      ad = deq && (q0.size() > 0);
      m_ovf  = (err_clr ? 1'b0 : m_ovf) | (enq && !ae);
      m_unf  = (err_clr ? 1'b0 : m_unf) | (deq && !ad);
      m_mask = (err_clr ? 3'b0 : m_mask) | d;
      if (ad) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
        void'(q2.pop_front());
      end
      if (ae) begin
        q0.push_back(din ^ 32'(inj_en && inj_sel == 2'd0));
        q1.push_back(din ^ 32'(inj_en && inj_sel == 2'd1));
        q2.push_back(din ^ 32'(inj_en && inj_sel == 2'd2));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_dout", dout, hd(0));
      chk("m_count", count, q0.size());
      chk("m_full", full, q0.size() == 8);
      chk("m_empty", empty, q0.size() == 0);
      chk("m_ovf", overflow, m_ovf);
      chk("m_unf", underflow, m_unf);
      chk("m_mask", mismatch_mask, m_mask);
      chk("m_mismatch", mismatch, |m_mask);
    end
  end

  task automatic cyc(input logic e, input logic d, input logic [31:0] v,
                     input logic ie, input logic [1:0] is, input logic c);
    enq = e;
    deq = d;
    din = v;
    inj_en = ie;
    inj_sel = is;
    err_clr = c;
    @(posedge clk);
    #1;
    enq = 1'b0;
    deq = 1'b0;
    din = '0;
    inj_en = 1'b0;
    inj_sel = '0;
    err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_mask", mismatch_mask, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) cyc(1, 0, 32'hA0 + i, 0, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 8);
    chk("fill_dout", dout, 32'hA0);
    chk("fill_mm", mismatch, 0);

    cyc(1, 1, 32'hB0, 0, 0, 0);
    chk("ed_count", count, 8);
    chk("ed_dout", dout, 32'hA1);
    chk("ed_ovf", overflow, 0);

    cyc(1, 0, 32'hC0, 0, 0, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_dout", dout, 32'hA1);
    chk("ovf_count", count, 8);

    cyc(0, 0, 0, 0, 0, 1);
    chk("ovf_clr", overflow, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0, 0);
    chk("drain_last", dout, 32'hB0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("drain_empty", empty, 1);

    cyc(0, 1, 0, 0, 0, 0);
    chk("unf_set", underflow, 1);
    chk("unf_count", count, 0);
    chk("unf_dout", dout, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("unf_clr", underflow, 0);

    cyc(1, 0, 32'h10, 1, 2, 0);
    chk("inj_dout", dout, 32'h10);
    chk("inj_mm0", mismatch, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("inj_mask", mismatch_mask, 3'b100);
    chk("inj_mm1", mismatch, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("clr_lose", mismatch_mask, 3'b100);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("clr_win", mismatch_mask, 0);

    cyc(1, 0, 32'h21, 0, 0, 0);
    cyc(1, 0, 32'h22, 0, 0, 0);
    cyc(1, 0, 32'h23, 1, 1, 0);
    cyc(1, 0, 32'h24, 0, 0, 0);
    chk("late_mm0", mismatch, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("late_head1", dout, 32'h22);
    chk("late_mm1", mismatch, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("late_head2", dout, 32'h23);
    chk("late_mm2", mismatch, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("late_mask", mismatch_mask, 3'b010);

    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h31 + i, 0, 0, 0);
    chk("pre_count", count, 5);
    chk("pre_mm", mismatch, 1);

    #3 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_mm", mismatch, 0);
    chk("arst_empty", empty, 1);
    chk("arst_dout", dout, 0);
    chk("arst_ovf", overflow, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 0, 32'h55, 0, 0, 0);
    chk("post_dout", dout, 32'h55);
    chk("post_count", count, 1);
    cyc(0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
